// File: rtl/i2s_tx_master_serializer.sv
// I2S master transmit serializer: pulls 32-bit words over valid/ready,
// generates SCK/WS and shifts each word onto SD in Philips I2S framing.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_en_i              transmitter enable (sampled at slot loads in RUN)
//   cfg_div_i             SCK half-period minus one, in clk_i cycles
//   cfg_bits_word_i       slot length minus one (0 behaves as 1)
//   cfg_lsb_first_i       1 = LSB first, 0 = MSB first
//   data_i/data_valid_i   sample word and its valid flag
//   data_ready_o          word consumed this cycle (slot load only)
//   sck_o, ws_o, sd_o     I2S serial clock, word select, serial data
//   busy_o                engine running
//   underrun_o            one-cycle pulse: slot started without data
module i2s_tx_master_serializer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [4:0]           cfg_bits_word_i,
  input  logic                 cfg_lsb_first_i,
  input  logic [31:0]          data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic                 sd_o,
  output logic                 busy_o,
  output logic                 underrun_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] presc;
  logic [4:0]           nm1_q;
  logic [4:0]           bit_idx;
  logic                 lsb_q;
  logic [31:0]          shreg;
  logic                 sck_q;
  logic                 ws_q;
  logic                 sd_q;
  logic                 under_q;

  logic                 run;
  logic                 tick;
  logic                 fall;
  logic                 slot_end;
  logic                 load;
  logic                 stop;
  logic [4:0]           idx_nx;
  logic [4:0]           cfg_nm1;
  logic                 first_bit;
  logic                 next_bit;

  // A one-bit slot is not legal I2S; clamp to two bits.
  assign cfg_nm1 = (cfg_bits_word_i == 5'd0) ? 5'd1 : cfg_bits_word_i;

  assign run      = (state == RUN);
  assign tick     = (presc == div_q);
  assign fall     = run && tick && sck_q;
  assign slot_end = (bit_idx == nm1_q);
  assign load     = fall && slot_end;
  // Stopping only happens at a left-slot load, so frames never split.
  assign stop     = load && !cfg_en_i && !ws_q;
  assign idx_nx   = bit_idx + 5'd1;

  assign first_bit = data_valid_i &&
                     (cfg_lsb_first_i_q() ? data_i[0] : data_i[nm1_q]);
  assign next_bit  = lsb_q ? shreg[idx_nx] : shreg[nm1_q - idx_nx];

  function automatic logic cfg_lsb_first_i_q();
    return lsb_q;
  endfunction

  assign data_ready_o = load && !stop && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      div_q   <= '0;
      presc   <= '0;
      nm1_q   <= '0;
      bit_idx <= '0;
      lsb_q   <= 1'b0;
      shreg   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      under_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          under_q <= 1'b0;
          sck_q   <= 1'b0;
          ws_q    <= 1'b0;
          sd_q    <= 1'b0;
          presc   <= '0;
          if (cfg_en_i) begin
            state   <= RUN;
            div_q   <= cfg_div_i;
            nm1_q   <= cfg_nm1;
            lsb_q   <= cfg_lsb_first_i;
            // Start at the slot-end marker so the first fall loads.
            bit_idx <= cfg_nm1;
          end
        end
        RUN: begin
          under_q <= 1'b0;
          if (tick) begin
            presc <= '0;
            sck_q <= ~sck_q;
          end else begin
            presc <= presc + 1'b1;
          end
          if (stop) begin
            state   <= IDLE;
            presc   <= '0;
            bit_idx <= '0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b0;
            sd_q    <= 1'b0;
          end else if (fall) begin
            if (slot_end) begin
              shreg   <= data_valid_i ? data_i : 32'd0;
              sd_q    <= first_bit;
              bit_idx <= 5'd0;
              under_q <= !data_valid_i;
            end else begin
              bit_idx <= idx_nx;
              sd_q    <= next_bit;
              // WS leads the next slot by one bit.
              if (idx_nx == nm1_q) ws_q <= ~ws_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sck_o      = sck_q;
  assign ws_o       = ws_q;
  assign sd_o       = sd_q;
  assign busy_o     = run;
  assign underrun_o = under_q;

endmodule

// File: tb/tb_i2s_tx_master_serializer.sv
// Self-checking bench for i2s_tx_master_serializer: a timing-arithmetic
// model checks every cycle; directed tests pin serialized bit sequences.
module tb_i2s_tx_master_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div = '0;
  logic [4:0]  bits = 5'd7;
  logic        lsb = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        busy;
  logic        under;

  i2s_tx_master_serializer #(.DIV_WIDTH(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_en_i        (en),
    .cfg_div_i       (div),
    .cfg_bits_word_i (bits),
    .cfg_lsb_first_i (lsb),
    .data_i          (data),
    .data_valid_i    (valid),
    .data_ready_o    (ready),
    .sck_o           (sck),
    .ws_o            (ws),
    .sd_o            (sd),
    .busy_o          (busy),
    .underrun_o      (under)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
  } ent_t;

  ent_t wq[$];
  bit   sdq[$];
  int   cmp_n = 0;
  int   err_n = 0;
  int   rdy_cnt = 0;
  int   ucyc = 0;
  int   ws_rise = 0;
  bit   took = 0;

  // model state
  bit          mrun = 0;
  int          t = 0;
  int          h = 1;
  int          nn = 2;
  bit          mlsb = 0;
  logic [31:0] mword = '0;
  bit          mund = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    cmp_n++;
    if (a !== e) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(bit v, logic [31:0] d);
    ent_t e;
    e.v = v;
    e.d = d;
    wq.push_back(e);
  endtask

  task automatic wait_rdy(int n, int budget);
    for (int i = 0; i < budget; i++) begin
      if (rdy_cnt >= n) break;
      cyc();
    end
    chk("rdy_timeout", 64'(rdy_cnt >= n), 64'd1);
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      cyc();
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_bits(int n, int budget);
    for (int i = 0; i < budget; i++) begin
      if (sdq.size() >= n) break;
      cyc();
    end
    chk("bits_timeout", 64'(sdq.size() >= n), 64'd1);
  endtask

  // pat is read MSB first: pat[n-1] is the first bit on the wire
  task automatic chk_seq(string nm, int base, logic [63:0] pat, int n);
    chk({nm, "_len"}, 64'(sdq.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < sdq.size())
        chk(nm, 64'(sdq[base + i]), 64'(pat[n - 1 - i]));
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    wq.delete();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    int sb;
    int rb;
    int ub;
    int wb;

    fork
      // data source: pops the head entry after each ready cycle
      forever begin
        @(posedge clk);
        #1;
        if (took && wq.size() > 0) void'(wq.pop_front());
        if (wq.size() > 0) begin
          valid = wq[0].v;
          data  = wq[0].d;
        end else begin
          valid = 1'b0;
          data  = '0;
        end
      end
      // model + per-cycle compare + observers
      forever begin : mdl
        int  k;
        int  b;
        bit  e_sck;
        bit  e_ws;
        bit  e_sd;
        bit  e_rdy;
        bit  ld;
        bit  prev_sck;
        @(negedge clk);
        e_sck = 0;
        e_ws  = 0;
        e_sd  = 0;
        ld    = 0;
        if (mrun) begin
          k     = t / (2 * h);
          e_sck = ((t / h) % 2) == 1;
          if (k > 0) begin
            b    = (k - 1) % nn;
            e_ws = ((k / nn) % 2) == 1;
            e_sd = mword[mlsb ? b : nn - 1 - b];
          end
          ld = ((t + 1) % (2 * h) == 0) &&
               ((((t + 1) / (2 * h)) - 1) % nn == 0);
        end
        e_rdy = ld && (en || e_ws) && !rst;
        chk("sck", 64'(sck), 64'(e_sck));
        chk("ws", 64'(ws), 64'(e_ws));
        chk("sd", 64'(sd), 64'(e_sd));
        chk("busy", 64'(busy), 64'(mrun));
        chk("underrun", 64'(under), 64'(mund));
        chk("ready", 64'(ready), 64'(e_rdy));
        if (prev_sck && !sck && busy) sdq.push_back(sd);
        if (!prev_sck && sck) begin end
        prev_sck = sck;
        if (ready) rdy_cnt++;
        if (under) ucyc++;
        took = ready;
        if (rst) begin
          mrun = 0;
          mund = 0;
        end else if (!mrun) begin
          mund = 0;
          if (en) begin
            mrun = 1;
            t    = 0;
            h    = int'(div) + 1;
            nn   = (bits == 0) ? 2 : int'(bits) + 1;
            mlsb = lsb;
          end
        end else if (ld && !en && !e_ws) begin
          mrun = 0;
          mund = 0;
        end else begin
          mund = 0;
          if (ld) begin
            mword = valid ? data : 32'd0;
            mund  = !valid;
          end
          if (k > 0 && ((t + 1) % (2 * h) == 0) &&
              ((((t + 1) / (2 * h))) % nn == 0))
            ws_rise += e_ws ? 0 : 1;
          t++;
        end
      end
    join_none

    do_reset();
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);

    // basic MSB-first, then disable during the right slot
    div = 16'd0; bits = 5'd7; lsb = 1'b0;
    push(1, 32'hA5);
    push(1, 32'h3C);
    sb = sdq.size(); rb = rdy_cnt; wb = ws_rise;
    en = 1'b1;
    wait_rdy(rb + 2, 200);
    en = 1'b0;
    wait_idle(200);
    chk_seq("msb_seq", sb, 64'hA53C, 16);
    chk("msb_rdy", 64'(rdy_cnt - rb), 64'd2);
    chk("msb_wsrise", 64'(ws_rise - wb), 64'd1);
    chk("msb_ws_idle", 64'(ws), 64'd0);

    // LSB-first
    do_reset();
    lsb = 1'b1;
    push(1, 32'hA5);
    push(1, 32'h80);
    sb = sdq.size(); rb = rdy_cnt;
    en = 1'b1;
    wait_rdy(rb + 2, 200);
    en = 1'b0;
    wait_idle(200);
    chk_seq("lsb_seq", sb, 64'hA501, 16);

    // underrun in the right slot
    do_reset();
    lsb = 1'b0;
    push(1, 32'hA5);
    push(0, 32'hFFFF_FFFF);
    push(1, 32'h3C);
    push(1, 32'h11);
    sb = sdq.size(); rb = rdy_cnt; ub = ucyc;
    en = 1'b1;
    wait_rdy(rb + 3, 400);
    en = 1'b0;
    wait_idle(400);
    chk_seq("udr_seq", sb, 64'hA5003C11, 32);
    chk("udr_cyc", 64'(ucyc - ub), 64'd1);
    chk("udr_rdy", 64'(rdy_cnt - rb), 64'd4);

    // long slots, slow SCK, config changes mid-RUN ignored
    do_reset();
    div = 16'd3; bits = 5'd31; lsb = 1'b0;
    push(1, 32'hDEAD_BEEF);
    push(1, 32'h1234_5678);
    sb = sdq.size(); rb = rdy_cnt;
    en = 1'b1;
    wait_rdy(rb + 1, 100);
    div = 16'd0; bits = 5'd7; lsb = 1'b1;
    wait_rdy(rb + 2, 1000);
    en = 1'b0;
    wait_idle(1000);
    chk_seq("long_seq", sb, 64'hDEADBEEF_12345678, 64);
    lsb = 1'b0;

    // disable in the middle of a left slot
    do_reset();
    div = 16'd1; bits = 5'd15;
    push(1, 32'hBEEF);
    push(1, 32'h1234);
    push(1, 32'hFFFF);
    sb = sdq.size(); rb = rdy_cnt;
    en = 1'b1;
    wait_rdy(rb + 1, 100);
    repeat (10) cyc();
    en = 1'b0;
    wait_idle(600);
    chk_seq("dis_seq", sb, 64'hBEEF1234, 32);
    chk("dis_rdy", 64'(rdy_cnt - rb), 64'd2);
    chk("dis_left", 64'(wq.size()), 64'd1);
    repeat (20) cyc();
    chk("dis_rdy_after", 64'(rdy_cnt - rb), 64'd2);
    chk("dis_sck", 64'(sck), 64'd0);
    chk("dis_sd", 64'(sd), 64'd0);

    // reset during bit 3 of a slot
    do_reset();
    div = 16'd1; bits = 5'd7;
    push(1, 32'hFF);
    push(1, 32'hFF);
    rb = rdy_cnt; sb = sdq.size();
    en = 1'b1;
    wait_bits(sb + 3, 200);
    rst = 1'b1;
    cyc();
    chk("mid_rst_sck", 64'(sck), 64'd0);
    chk("mid_rst_sd", 64'(sd), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    wq.delete();
    push(1, 32'h5A);
    push(1, 32'h0F);
    rst = 1'b0;
    sb = sdq.size(); rb = rdy_cnt;
    wait_rdy(rb + 2, 200);
    en = 1'b0;
    wait_idle(200);
    chk_seq("rst_seq", sb, 64'h5A0F, 16);

    // minimum slot: bits_word 0 acts as 2-bit slots
    do_reset();
    div = 16'd0; bits = 5'd0;
    push(1, 32'hFFFF_FFF2);
    push(1, 32'h0000_0001);
    sb = sdq.size(); rb = rdy_cnt;
    en = 1'b1;
    wait_rdy(rb + 2, 100);
    en = 1'b0;
    wait_idle(100);
    chk_seq("n2_seq", sb, 64'h9, 4);

    repeat (4) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
